// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default timing constants,
// common to the transmitter and receiver.
package uart_pkg;

  localparam int unsigned DEFAULT_CLOCK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;
  localparam int unsigned UART_DATA_BITS     = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Bit-period timer: free-running counter that wraps at CLKS_PER_BIT-1 and
// flags the last clock of each bit period with a one-cycle tick.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST) && !clear;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one byte when idle and serialises it as
// start / 8 data bits LSB first / optional parity / 1 or 2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [2:0]  LAST_DATA    = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);
  localparam logic        PARITY_INV   = (PARITY_ODD != 0);
  localparam logic        HAS_PARITY   = (PARITY_EN != 0);

  uart_state_t state, state_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift_reg, shift_reg_n;
  logic        parity_q, parity_n;
  logic        tx_n, busy_n, tx_done_n;
  logic        tick;

  // Counter held at zero while idle, so it starts from 0 on entering START.
  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shift_reg <= '0;
      parity_q  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_reg_n;
      parity_q  <= parity_n;
      tx        <= tx_n;
      busy      <= busy_n;
      tx_done   <= tx_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    parity_n    = parity_q;

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_n     = START;
          shift_reg_n = tx_data;
          parity_n    = (^tx_data) ^ PARITY_INV;
          bit_idx_n   = '0;
        end
      end
      START: begin
        if (tick) state_n = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_reg_n = {1'b0, shift_reg[7:1]};
          if (bit_idx == LAST_DATA) begin
            bit_idx_n = '0;
            state_n   = HAS_PARITY ? PARITY : STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) state_n = STOP;
      end
      STOP: begin
        // bit_idx is reused to count stop bits
        if (tick) begin
          if (bit_idx == LAST_STOP) begin
            bit_idx_n = '0;
            state_n   = IDLE;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        state_n   = IDLE;
        bit_idx_n = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered line
  // changes on the same edge as the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_reg_n[0];
      PARITY:  tx_n = parity_n;
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
    busy_n    = (state_n != IDLE);
    tx_done_n = (state != IDLE) && (state_n == IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed self-checking bench for uart_tx_serializer at 10 clocks per bit,
// four instances covering plain, even/odd parity and two-stop-bit framing.
module tb_uart_tx_serializer;

  localparam int CPB = 10;

  logic       clock;
  logic       reset;
  logic [7:0] tx_data;
  logic       start   [4];
  logic       tx_w    [4];
  logic       busy_w  [4];
  logic       done_w  [4];

  int n_cmp;
  int n_err;

  uart_tx_serializer #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_plain (.clock(clock), .reset(reset), .tx_start(start[0]), .tx_data(tx_data),
               .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx_serializer #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_even (.clock(clock), .reset(reset), .tx_start(start[1]), .tx_data(tx_data),
              .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx_serializer #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    dut_odd (.clock(clock), .reset(reset), .tx_start(start[2]), .tx_data(tx_data),
             .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx_serializer #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    dut_stop2 (.clock(clock), .reset(reset), .tx_start(start[3]), .tx_data(tx_data),
               .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data);
    @(negedge clock);
    tx_data  = data;
    start[d] = 1'b1;
    @(posedge clock);
    #1;
    start[d] = 1'b0;
  endtask

  // Called right after the acceptance edge. bits[i] is the i-th line bit.
  task automatic watch_frame(input int d, input string tag, input logic [11:0] bits,
                             input int nbits, input int next_data, input int mutate_at);
    int dev;
    int bsy;
    dev = 0;
    bsy = 0;
    for (int k = 0; k < nbits * CPB; k++) begin
      @(negedge clock);
      if (k == mutate_at) begin
        tx_data  = 8'h00;
        start[d] = 1'b1;
      end
      if (k == mutate_at + 3) start[d] = 1'b0;
      if (tx_w[d] !== bits[k / CPB]) dev++;
      if (busy_w[d] !== 1'b1) bsy++;
      if (done_w[d] !== 1'b0) dev++;
    end
    check({tag, "_line"}, dev, 0);
    check({tag, "_busy_len"}, bsy, 0);
    @(negedge clock);
    check({tag, "_done"}, done_w[d], 1);
    check({tag, "_busy_fall"}, busy_w[d], 0);
    check({tag, "_idle_tx"}, tx_w[d], 1);
    if (next_data >= 0) begin
      tx_data  = next_data[7:0];
      start[d] = 1'b1;
      @(posedge clock);
      #1;
      start[d] = 1'b0;
    end else begin
      @(negedge clock);
      check({tag, "_done_pulse"}, done_w[d], 0);
    end
  endtask

  initial begin
    int cnt;
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    tx_data = 8'h00;
    for (int i = 0; i < 4; i++) start[i] = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), tx_w[i], 1);
      check($sformatf("rst_busy%0d", i), busy_w[i], 0);
      check($sformatf("rst_done%0d", i), done_w[i], 0);
    end
    reset = 1'b0;

    // 0xA5: start 0, data 1,0,1,0,0,1,0,1, stop 1
    send(0, 8'hA5);
    watch_frame(0, "a5", 12'b00_1101001010, 10, -1, -1);
    // 0x07 has three ones: even parity 1, odd parity 0
    send(1, 8'h07);
    watch_frame(1, "par_even", 12'b0_11000001110, 11, -1, -1);
    send(2, 8'h07);
    watch_frame(2, "par_odd", 12'b0_10000001110, 11, -1, -1);
    send(3, 8'h00);
    watch_frame(3, "stop2", 12'b0_11000000000, 11, -1, -1);

    // back-to-back: 0x32 requested in the tx_done cycle of 0x31
    send(0, 8'h31);
    watch_frame(0, "b2b_31", 12'b00_1001100010, 10, 32'h32, -1);
    watch_frame(0, "b2b_32", 12'b00_1001100100, 10, -1, -1);

    // start and new data while busy must be ignored
    send(0, 8'hFF);
    watch_frame(0, "busy_ign", 12'b00_1111111110, 10, -1, 25);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || done_w[0] !== 1'b0) cnt++;
    end
    check("no_extra_frame", cnt, 0);

    // reset 45 clocks into a frame
    send(0, 8'hA5);
    repeat (45) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_tx", tx_w[0], 1);
    check("abort_busy", busy_w[0], 0);
    cnt = 0;
    repeat (3) begin
      @(negedge clock);
      if (done_w[0] !== 1'b0) cnt++;
    end
    reset = 1'b0;
    @(negedge clock);
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) cnt++;
    check("abort_no_done", cnt, 0);
    send(0, 8'h3C);
    watch_frame(0, "post_rst", 12'b00_1001111000, 10, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 = parity bit inserted after data.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-006 SHALL have port clock, input, 1, rising-edge system clock.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port tx_start, input, 1, request to send tx_data; sampled only while busy=0.
REQ-009 SHALL have port tx_data, input, 8, byte to transmit; sampled with tx_start.
REQ-010 SHALL have port tx, output, 1, serial line, idle high.
REQ-011 SHALL have port busy, output, 1, high while a frame is in progress; drives the arbiter's uart_busy input.
REQ-012 SHALL have port tx_done, output, 1, one-cycle pulse at frame end.

Function
REQ-013 SHALL derive CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE (integer divide, 434 at defaults); each line bit SHALL last exactly CLKS_PER_BIT clocks.
REQ-014 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY_EN=0.
REQ-015 IDLE: tx=1, busy=0; on tx_start=1 SHALL latch tx_data into a shift register and go to START at the same edge.
REQ-016 START: tx=0 for CLKS_PER_BIT clocks, then DATA.
REQ-017 DATA: SHALL send 8 bits LSB first, bit index 0..7, then PARITY or STOP.
REQ-018 PARITY: tx = XOR of latched byte (even), inverted when PARITY_ODD=1.
REQ-019 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT clocks, then IDLE.
REQ-020 tx and busy SHALL be registered outputs; busy=1 in every state except IDLE, so busy rises the cycle after acceptance.
REQ-021 Frame length (acceptance edge to return to IDLE) SHALL be (9 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
REQ-022 tx_done SHALL be high for exactly the one cycle in which state first returns to IDLE, coincident with busy falling.
REQ-023 tx_start and tx_data SHALL be ignored while busy=1; changes to tx_data after acceptance SHALL NOT affect the frame.
REQ-024 tx_start asserted in the cycle tx_done is high SHALL be accepted (back-to-back frames, one idle-high clock between them).
REQ-025 tx_start held high continuously SHALL produce consecutive frames, one per acceptance; senders SHALL pulse it for one cycle per byte.
REQ-026 Baud counter SHALL wrap from CLKS_PER_BIT-1 to 0 and SHALL be cleared on entering START.

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, tx=1, busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
REQ-028 reset asserted mid-frame SHALL abort the frame, immediately return tx high, and SHALL NOT pulse tx_done.
REQ-029 After reset release the first tx_start SHALL be accepted on the first rising edge where it is sampled high.

Structure
REQ-030 State encoding and default CLOCK_FREQ/BAUD_RATE constants SHALL live in shared package uart_pkg, also used by the receiver.
REQ-031 Bit-period timing SHALL be a sub-module baud_tick_gen (counter, clear input, one-cycle tick output at CLKS_PER_BIT-1).
REQ-032 No FIFO inside this block; buffering is the responsibility of the upstream senders.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so CLKS_PER_BIT=10)
REQ-033 Send 0xA5, PARITY_EN=0, STOP_BITS=1 -> tx = 0,1,0,1,0,0,1,0,1,1 at 10 clocks per bit; busy high 100 clocks; one tx_done pulse.
REQ-034 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; PARITY_ODD=1 -> parity bit 0; frame 110 clocks.
REQ-035 STOP_BITS=2, send 0x00 -> stop high for 20 clocks; total frame 110 clocks.
REQ-036 tx_start 0x31 then 0x32 issued in the tx_done cycle -> two frames separated by exactly one idle-high clock; 0x32 on line intact.
REQ-037 tx_start while busy with tx_data=0xFF, then modify tx_data mid-frame -> line carries only the original byte; no extra frame.
REQ-038 reset pulse at clock 45 of a frame -> tx=1 and busy=0 immediately, no tx_done; next tx_start sends a clean frame.
